serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing d = a - b - bin, one bit per clock, LSB first.
- Shares the borrow/carry chain concept with the datapath adder but trades area for latency. It is an area-minimal ALU subtract path for the CPU datapath.
- Start/busy/done handshake; result and flags held until the next completion.

---
 rtl/serial_subtractor.sv | 142 ++++++++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, d = a - b - bin, LSB first.
// One bit is handled per clock. The start/busy/done handshake accepts a new
// request in IDLE or in the DONE cycle, so back-to-back operations have no gap.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // One extra counter bit so the count can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, d_q, d_d;
  logic             brw_q, brw_d, bout_q, bout_d, zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single-bit full-subtractor cell working on the current operand LSBs.
  logic             diff, brw_nxt, last;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    diff    = a_q[0] ^ b_q[0] ^ brw_q;
    brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    res_nxt = {diff, res_q[WIDTH-1:1]};
    last    = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state, datapath shift and result-capture logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nxt;
        res_d = res_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // Outputs only move here, so they hold through DONE and beyond.
          d_d     = res_nxt;
          bout_d  = brw_nxt;
          zero_d  = (res_nxt == '0);
`ifdef SERIAL_SUB_OVF_EN
          // a_q[0]/b_q[0] now hold the original operand MSBs; diff is the result MSB.
          ovf_d   = (a_q[0] != b_q[0]) && (diff != a_q[0]);
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    d    = d_q;
    bout = bout_q;
    zero = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf  = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level arithmetic model plus directed
// vectors with hand-computed results.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk, rst, start, bin;
  logic [W-1:0] a, b, d;
  logic         bout, zero, busy, done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int vectors = 0, miscompares = 0;
  int cyc = 0, t0 = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .d(d), .bout(bout), .zero(zero), .busy(busy), .done(done)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: countdown of cycles left in the operation, results from plain arithmetic.
  int           m_left;
  logic [W-1:0] m_d, p_d;
  logic         m_bout, p_bout, m_zero, p_zero, m_ovf, p_ovf;
  int           ai, bi, ci;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_d = '0; m_bout = 0; m_zero = 0; m_ovf = 0;
      p_d = '0; p_bout = 0; p_zero = 0; p_ovf = 0;
    end else begin
      if (m_left == 2) begin
        m_d = p_d; m_bout = p_bout; m_zero = p_zero; m_ovf = p_ovf;
      end
      if (m_left <= 1 && start) begin
        ai = int'(a); bi = int'(b); ci = int'(bin);
        p_d    = W'(ai - bi - ci);
        p_bout = (ai < bi + ci);
        p_zero = (p_d == 0);
        p_ovf  = (a[W-1] != b[W-1]) && (p_d[W-1] != a[W-1]);
        m_left = W + 1;
      end else if (m_left > 0) begin
        m_left--;
      end
    end
  end

  // Every cycle outside reset, DUT outputs must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, m_left >= 2);
      chk("done", done, m_left == 1);
      chk("d", d, m_d);
      chk("bout", bout, m_bout);
      chk("zero", zero, m_zero);
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", ovf, m_ovf);
`endif
    end
  end

  // Present a start for one edge, then scramble the operand inputs.
  task automatic go(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    a = av; b = bv; bin = cv; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Wait (bounded) for done; returns at the negedge of the done cycle.
  task automatic wait_done(input string nm, input logic [W-1:0] ed, input logic eb,
                           input logic ez, input logic eo);
    bit seen = 0;
    for (int k = 0; k < W + 4 && !seen; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk({nm, "_latency"}, cyc - t0, W + 1);
        chk({nm, "_d"}, d, ed);
        chk({nm, "_bout"}, bout, eb);
        chk({nm, "_zero"}, zero, ez);
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, "_ovf"}, ovf, eo);
`endif
      end
    end
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    if (eo) ; // ovf expectation only matters when the port exists
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(negedge clk);
    chk("rst_d", d, 0); chk("rst_bout", bout, 0); chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle_cycle();

    // 1: 9 - 3 = 6, busy cycles 1..4, done in cycle 5
    go(4'd9, 4'd3, 1'b0);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      chk("t1_busy", busy, 1);
    end
    wait_done("t1", 4'd6, 0, 0, 0);
    idle_cycle();

    // 2: 3 - 9 wraps to 0xA with borrow; 0 - 0 - 1 = 0xF with borrow
    go(4'd3, 4'd9, 1'b0);
    wait_done("t2a", 4'hA, 1, 0, 0);
    idle_cycle();
    go(4'd0, 4'd0, 1'b1);
    wait_done("t2b", 4'hF, 1, 0, 1'b0);
    idle_cycle();

    // 3: 5 - 5 = 0, then the result must hold for 10 idle cycles
    go(4'd5, 4'd5, 1'b0);
    wait_done("t3", 4'd0, 0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_d", d, 0);
      chk("t3_hold_zero", zero, 1);
    end
    idle_cycle();

    // 4: start during RUN ignored; start in the done cycle accepted
    go(4'd9, 4'd3, 1'b0);          // now in cycle 1
    idle_cycle();                  // cycle 2
    a = 4'd1; b = 4'd1; bin = 1'b0; start = 1'b1;
    idle_cycle();
    start = 1'b0;
    wait_done("t4a", 4'd6, 0, 0, 0);
    go(4'd7, 4'd2, 1'b0);          // issued in the done cycle
    wait_done("t4b", 4'd5, 0, 0, 0);
    idle_cycle();

    // 5: async reset mid-operation clears everything, no done follows
    go(4'd9, 4'd3, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t5_d", d, 0); chk("t5_bout", bout, 0); chk("t5_zero", zero, 0);
    chk("t5_busy", busy, 0); chk("t5_done", done, 0);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      chk("t5_no_done", done, 0);
    end
    idle_cycle();
    go(4'd9, 4'd3, 1'b0);
    wait_done("t5_after", 4'd6, 0, 0, 0);
    idle_cycle();

    // 6: signed overflow -8 - 1, then a clean 4 - 2
    go(4'd8, 4'd1, 1'b0);
    wait_done("t6a", 4'd7, 0, 0, 1);
    idle_cycle();
    go(4'd4, 4'd2, 1'b0);
    wait_done("t6b", 4'd2, 0, 0, 0);
    repeat (3) idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
